// File: rtl/dht11_uart_report_if.sv
// Signal bundle between the DHT11 reading source and the ASCII/UART reporter.
// The master drives the reading; the slave (reporter) drives line and status.
interface dht11_uart_report_if;
  logic [39:0] t_h_data;
  logic        uart_txd;
  logic        busy;
  logic        frame_done;

  modport master (
    output t_h_data,
    input  uart_txd,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  t_h_data,
    output uart_txd,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/dht11_uart_report.sv
// Turns each new DHT11 reading into the 17-byte text "H:hhh.d T:ttt.d\r\n"
// and shifts it out on an 8N1 UART line, LSB first, with no gap between characters.
module dht11_uart_report #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  dht11_uart_report_if.slave   bus
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD;
  localparam int BW       = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  state_t          r_state;
  logic [31:0]     r_last_data;
  logic [31:0]     r_snap;
  logic [3:0]      r_conv_cnt;
  logic [19:0]     r_dd;
  logic [11:0]     r_hum_bcd;
  logic [11:0]     r_tmp_bcd;
  logic [BW-1:0]   r_baud_cnt;
  logic [3:0]      r_bit_cnt;
  logic [4:0]      r_char_idx;
  logic            r_last_bit;
  logic            r_txd;
  logic            r_busy;
  logic            r_frame_done;

  logic [19:0]     w_dd_src;
  logic [19:0]     w_dd_next;
  logic [7:0]      w_char;
  logic [2:0]      w_bit_idx;
  logic            w_tx_bit;
  logic            w_unused_chk;

  // One double-dabble iteration: BCD lives in [19:8], binary shifts out of [7:0].
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    if (t[11:8] >= 4'd5) t[11:8] = t[11:8] + 4'd3;
    else                 t[11:8] = t[11:8];
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    else                  t[15:12] = t[15:12];
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    else                  t[19:16] = t[19:16];
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [7:0] bcd_ascii(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  // Decimal bytes get one digit; anything above 9 is clamped to '9'.
  function automatic logic [7:0] dec_ascii(input logic [7:0] v);
    if (v > 8'd9) return 8'h39;
    else          return 8'h30 + v;
  endfunction

  assign bus.uart_txd   = r_txd;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign w_unused_chk   = ^bus.t_h_data[7:0];

  // Converter input: reload from the snapshot at the start of each byte.
  always_comb begin
    w_dd_src = r_dd;
    if (r_conv_cnt[2:0] == 3'd0) begin
      w_dd_src = {12'd0, (r_conv_cnt[3] ? r_snap[15:8] : r_snap[31:24])};
    end else begin
      w_dd_src = r_dd;
    end
    w_dd_next = dd_step(w_dd_src);
  end

  // Character currently on the wire, selected by frame index.
  always_comb begin
    w_char = 8'h0A;
    case (r_char_idx)
      5'd0:    w_char = 8'h48;
      5'd1:    w_char = 8'h3A;
      5'd2:    w_char = bcd_ascii(r_hum_bcd[11:8]);
      5'd3:    w_char = bcd_ascii(r_hum_bcd[7:4]);
      5'd4:    w_char = bcd_ascii(r_hum_bcd[3:0]);
      5'd5:    w_char = 8'h2E;
      5'd6:    w_char = dec_ascii(r_snap[23:16]);
      5'd7:    w_char = 8'h20;
      5'd8:    w_char = 8'h54;
      5'd9:    w_char = 8'h3A;
      5'd10:   w_char = bcd_ascii(r_tmp_bcd[11:8]);
      5'd11:   w_char = bcd_ascii(r_tmp_bcd[7:4]);
      5'd12:   w_char = bcd_ascii(r_tmp_bcd[3:0]);
      5'd13:   w_char = 8'h2E;
      5'd14:   w_char = dec_ascii(r_snap[7:0]);
      5'd15:   w_char = 8'h0D;
      5'd16:   w_char = 8'h0A;
      default: w_char = 8'h0A;
    endcase
  end

  // Serial bit for the current slot: start, d0..d7, stop.
  always_comb begin
    w_bit_idx = 3'(r_bit_cnt - 4'd1);
    w_tx_bit  = 1'b1;
    case (r_bit_cnt)
      4'd0:    w_tx_bit = 1'b0;
      4'd9:    w_tx_bit = 1'b1;
      default: w_tx_bit = w_char[w_bit_idx];
    endcase
  end

  // Main FSM: change detect, conversion, frame build and serialisation.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= ST_IDLE;
      r_last_data  <= 32'd0;
      r_snap       <= 32'd0;
      r_conv_cnt   <= 4'd0;
      r_dd         <= 20'd0;
      r_hum_bcd    <= 12'd0;
      r_tmp_bcd    <= 12'd0;
      r_baud_cnt   <= {BW{1'b0}};
      r_bit_cnt    <= 4'd0;
      r_char_idx   <= 5'd0;
      r_last_bit   <= 1'b0;
      r_txd        <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_txd <= 1'b1;
          if (bus.t_h_data[39:8] != r_last_data) begin
            r_snap      <= bus.t_h_data[39:8];
            r_last_data <= bus.t_h_data[39:8];
            r_busy      <= 1'b1;
            r_conv_cnt  <= 4'd0;
            r_state     <= ST_CONV;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_CONV: begin
          r_dd       <= w_dd_next;
          r_conv_cnt <= r_conv_cnt + 4'd1;
          if (r_conv_cnt == 4'd7) begin
            r_hum_bcd <= w_dd_next[19:8];
          end else if (r_conv_cnt == 4'd15) begin
            r_tmp_bcd <= w_dd_next[19:8];
            r_state   <= ST_LOAD;
          end else begin
            r_state <= ST_CONV;
          end
        end
        ST_LOAD: begin
          r_baud_cnt <= {BW{1'b0}};
          r_bit_cnt  <= 4'd0;
          r_char_idx <= 5'd0;
          r_last_bit <= 1'b0;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          if (r_last_bit) begin
            // Edge that ends the final stop bit.
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
            r_txd        <= 1'b1;
            r_last_bit   <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            if (r_baud_cnt == {BW{1'b0}}) r_txd <= w_tx_bit;
            else                          r_txd <= r_txd;
            if (r_baud_cnt == BAUD_MAX) begin
              r_baud_cnt <= {BW{1'b0}};
              if (r_bit_cnt == 4'd9) begin
                r_bit_cnt <= 4'd0;
                if (r_char_idx == 5'd16) r_last_bit <= 1'b1;
                else                     r_char_idx <= r_char_idx + 5'd1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end else begin
              r_baud_cnt <= r_baud_cnt + BW'(1);
            end
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_uart_report.sv
// Directed bench for dht11_uart_report: decodes the UART line bit by bit and
// compares characters, latency, busy and frame_done against hand-computed values.
module tb_dht11_uart_report;
  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dht11_uart_report_if bus ();

  dht11_uart_report #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_buf [0:16];
  logic [7:0] rx_buf  [0:16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_exp(input string s);
    for (int i = 0; i < 17; i++) exp_buf[i] = s[i];
  endtask

  task automatic quiet(input string tag, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.uart_txd !== 1'b1 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) ok = 1'b0;
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic wait_start(input string tag, input int set_cyc, output int s_cyc);
    s_cyc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.uart_txd === 1'b0) begin
        s_cyc = cyc;
        break;
      end
    end
    check($sformatf("%s_start_latency", tag), 64'(s_cyc - set_cyc), 64'd19);
  endtask

  task automatic rx_frame(input string tag, input int s_cyc, input logic mid_change,
                          input logic [39:0] a, input logic [39:0] b, output int done_cyc);
    logic ok_frame;
    logic ok_busy;
    ok_frame = 1'b1;
    ok_busy  = 1'b1;
    for (int c = 0; c < 17; c++) begin
      for (int bt = 0; bt < 10; bt++) begin
        repeat ((c == 0 && bt == 0) ? 5 : 10) @(negedge clk);
        if (bt == 0)      ok_frame &= (bus.uart_txd === 1'b0);
        else if (bt == 9) ok_frame &= (bus.uart_txd === 1'b1);
        else              rx_buf[c][bt-1] = bus.uart_txd;
        if (bus.busy !== 1'b1) ok_busy = 1'b0;
        if (mid_change && c == 6 && bt == 0) bus.t_h_data = a;
        if (mid_change && c == 7 && bt == 0) bus.t_h_data = b;
      end
      check($sformatf("%s_char%0d", tag, c), rx_buf[c], exp_buf[c]);
    end
    check($sformatf("%s_framing", tag), ok_frame, 1'b1);
    check($sformatf("%s_busy_during", tag), ok_busy, 1'b1);
    done_cyc = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    check($sformatf("%s_done_latency", tag), 64'(done_cyc - s_cyc), 64'd1700);
    check($sformatf("%s_busy_at_done", tag), bus.busy, 1'b0);
    check($sformatf("%s_line_at_done", tag), bus.uart_txd, 1'b1);
    @(negedge clk);
    check($sformatf("%s_done_pulse_width", tag), bus.frame_done, 1'b0);
  endtask

  initial begin
    int set_cyc;
    int s_cyc;
    int done_cyc;
    logic [39:0] val_a;
    logic [39:0] val_b;

    val_a = {8'd99, 8'd1, 8'd99, 8'd1, 8'd7};
    val_b = {8'd255, 8'd12, 8'd0, 8'd9, 8'd0};

    // Reset state
    bus.t_h_data = 40'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_txd", bus.uart_txd, 1'b1);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.frame_done, 1'b0);
    rst_n = 1'b1;

    // Zero data after reset: nothing sent
    quiet("idle_zero_5000", 5000);

    // First frame; two changes mid-frame must not disturb it
    bus.t_h_data = {8'd45, 8'd0, 8'd23, 8'd5, 8'd73};
    set_cyc = cyc;
    wait_start("f1", set_cyc, s_cyc);
    set_exp("H:045.0 T:023.5\r\n");
    rx_frame("f1", s_cyc, 1'b1, val_a, val_b, done_cyc);

    // Exactly one follow-up frame, carrying the latest value (clamp + leading zeros)
    wait_start("f2", done_cyc, s_cyc);
    set_exp("H:255.9 T:000.9\r\n");
    rx_frame("f2", s_cyc, 1'b0, val_a, val_b, done_cyc);

    // Checksum-only change: no frame, and no third frame for the dropped value
    bus.t_h_data = {val_b[39:8], 8'hAA};
    quiet("checksum_only", 400);

    // Decimal 9 passes through, decimal 10 clamps
    bus.t_h_data = {8'd100, 8'd9, 8'd7, 8'd10, 8'd3};
    set_cyc = cyc;
    wait_start("f3", set_cyc, s_cyc);
    set_exp("H:100.9 T:007.9\r\n");
    rx_frame("f3", s_cyc, 1'b0, val_a, val_b, done_cyc);

    // Reset in the middle of char 8, then full restart from char 0
    bus.t_h_data = {8'd62, 8'd3, 8'd19, 8'd8, 8'h11};
    set_cyc = cyc;
    wait_start("f4", set_cyc, s_cyc);
    repeat (845) @(negedge clk);
    check("f4_busy_before_abort", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_txd", bus.uart_txd, 1'b1);
    check("abort_busy", bus.busy, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_hold_txd", bus.uart_txd, 1'b1);
    rst_n = 1'b1;
    set_cyc = cyc;
    wait_start("f5", set_cyc, s_cyc);
    set_exp("H:062.3 T:019.8\r\n");
    rx_frame("f5", s_cyc, 1'b0, val_a, val_b, done_cyc);
    quiet("after_restart", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
